// File: rtl/lsu_pkg.sv
// Package for the load/store memory-access stage.
// Contents:
//   - Access size encodings: SZ_WORD, SZ_HALF, SZ_BYTE. Encoding 3 is illegal and behaves as a word.
//   - Byte-enable constants.
//   - The FSM state enum.
//   - An alignment helper, used when MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [3:0] BE_WORD     = 4'b1111;
  localparam logic [3:0] BE_HALF_LO  = 4'b0011;
  localparam logic [3:0] BE_HALF_MID = 4'b0110;
  localparam logic [3:0] BE_HALF_HI  = 4'b1100;
  localparam logic [3:0] BE_BYTE0    = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    MIS  = 2'd3
  } lsu_state_e;

  // Halves may sit at any even offset.
  // Words (including illegal size 3) must sit at offset 0.
  // Bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store lane alignment (purely combinational).
// Ports:
//   size       in  2   access size (lsu_pkg SZ_* encoding; 3 treated as word)
//   off        in  2   byte offset addr[1:0]
//   wdata      in  32  store data, LSB-justified
//   be         out 4   byte enables
//   lane_data  out 32  store data moved onto the enabled byte lanes
// Placement rules:
//   - A half at offset 3 uses the upper half lanes. This matches the
//     downstream sign-extension unit's lane selection.
//   - A byte store replicates the byte onto all four lanes.
//   - A word ignores the offset.
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  always_comb begin
    be        = BE_WORD;
    lane_data = wdata;
    case (size)
      SZ_HALF: begin
        case (off)
          2'd0: begin
            be        = BE_HALF_LO;
            lane_data = {16'h0000, wdata[15:0]};
          end
          2'd1: begin
            be        = BE_HALF_MID;
            lane_data = {8'h00, wdata[15:0], 8'h00};
          end
          default: begin
            be        = BE_HALF_HI;
            lane_data = {wdata[15:0], 16'h0000};
          end
        endcase
      end
      SZ_BYTE: begin
        be        = BE_BYTE0 << off;
        lane_data = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory-access stage between EX and WB.
//
// Behaviour:
//   - Takes one load/store from EX.
//   - Runs the dmem req/gnt/rvalid handshake.
//   - Returns the raw read word plus its address, size and unsigned flag
//     to the downstream sign-extension unit.
//
// Optional feature, macro MISALIGN_TRAP_EN:
//   - Misaligned halves and words issue no request.
//   - Instead they pulse the extra 'misalign' output.
//
// Parameter:
//   TIMEOUT_CYCLES  number of WAIT cycles before a load reports bus_err (2..255)
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   ex_*            operation from EX (valid/ready)
//   dmem_*          data-memory request/response
//   wb_*            captured load result; only wb_valid pulses
//   st_done         1-cycle pulse: store granted
//   bus_err         1-cycle pulse: load timed out
//   misalign        1-cycle pulse: misaligned access (only with MISALIGN_TRAP_EN)
//
// Handshakes:
//   - EX transfer happens on a cycle where ex_valid && ex_ready.
//   - ex_ready is high only in IDLE with reset released.
//   - dmem_req and all dmem_* fields stay stable from the first REQ cycle
//     until the cycle where dmem_gnt is sampled high.
//   - dmem_rvalid counts only together with gnt in REQ, or in WAIT.
//     At any other time it is ignored.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_we,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_din,
  output logic [31:0] wb_addr,
  output logic [1:0]  wb_signext_sel,
  output logic        wb_func3,
  output logic        st_done,
  output logic        bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  to_cnt_q;

  // Operation latched at acceptance; it drives dmem_* while REQ is held.
  logic        op_we_q;
  logic [1:0]  op_size_q;
  logic        op_unsigned_q;
  logic [31:0] op_addr_q;
  logic [3:0]  op_be_q;
  logic [31:0] op_wdata_q;

  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Single-cycle decisions produced by the next-state logic.
  logic        latch_op;
  logic        capture;
  logic        st_grant;
  logic        timeout;

  lsu_store_align u_align (
    .size      (ex_size),
    .off       (ex_addr[1:0]),
    .wdata     (ex_wdata),
    .be        (st_be),
    .lane_data (st_data)
  );

  always_comb begin
    state_d  = state_q;
    latch_op = 1'b0;
    capture  = 1'b0;
    st_grant = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          latch_op = 1'b1;
          state_d  = REQ;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(ex_size, ex_addr[1:0])) state_d = MIS;
`endif
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (op_we_q) begin
            st_grant = 1'b1;
            state_d  = IDLE;
          end else if (dmem_rvalid) begin
            // Zero-wait memory: data comes back in the grant cycle.
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // rvalid is checked first so data on the last allowed cycle still wins.
        if (dmem_rvalid) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      MIS: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      to_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= (state_q == WAIT) ? to_cnt_q + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we_q       <= 1'b0;
      op_size_q     <= 2'd0;
      op_unsigned_q <= 1'b0;
      op_addr_q     <= 32'd0;
      op_be_q       <= 4'd0;
      op_wdata_q    <= 32'd0;
    end else if (latch_op) begin
      op_we_q       <= ex_we;
      op_size_q     <= ex_size;
      op_unsigned_q <= ex_unsigned;
      op_addr_q     <= ex_addr;
      op_be_q       <= ex_we ? st_be : BE_WORD;
      op_wdata_q    <= ex_we ? st_data : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      st_done        <= 1'b0;
      bus_err        <= 1'b0;
      wb_din         <= 32'd0;
      wb_addr        <= 32'd0;
      wb_signext_sel <= 2'd0;
      wb_func3       <= 1'b0;
    end else begin
      wb_valid <= capture;
      st_done  <= st_grant;
      bus_err  <= timeout;
      if (capture) begin
        wb_din         <= dmem_rdata;
        wb_addr        <= op_addr_q;
        wb_signext_sel <= op_size_q;
        wb_func3       <= op_unsigned_q;
      end
    end
  end

  // Request is a decode of state: the async reset removes it immediately.
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = op_we_q;
  assign dmem_addr  = {op_addr_q[31:2], 2'b00};
  assign dmem_be    = op_be_q;
  assign dmem_wdata = op_wdata_q;
  assign ex_ready   = rst_n && (state_q == IDLE);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (state_q == MIS);
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus randomized traffic.
// Responses are pushed to exp_q at issue and popped by a negedge monitor.
module tb_lsu_mem_ctrl;

  localparam int T = 16;
  localparam int W = 69;  // {kind[1:0], din[31:0], addr[31:0], size[1:0], uns}
  localparam logic [1:0] K_MIS = 2'd0, K_ST = 2'd1, K_WB = 2'd2, K_ERR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_we = 1'b0, ex_unsigned = 1'b0;
  logic [1:0]  ex_size = 2'd0;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic        ex_ready;
  logic        dmem_req, dmem_we;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_func3, st_done, bus_err;
  logic [31:0] wb_din, wb_addr;
  logic [1:0]  wb_signext_sel;
  logic        mis_sig;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_din(wb_din), .wb_addr(wb_addr),
    .wb_signext_sel(wb_signext_sel), .wb_func3(wb_func3), .st_done(st_done),
    .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
    , .misalign(mis_sig)
`endif
  );
`ifndef MISALIGN_TRAP_EN
  assign mis_sig = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] resp(input logic [1:0] kind, input logic [31:0] din,
                                         input logic [31:0] addr, input logic [1:0] sz,
                                         input logic uns);
    return {kind, din, addr, sz, uns};
  endfunction

  // Bytes occupied by a store: halves at offset 3 fall back to the upper half.
  function automatic int lane_len(input logic [1:0] sz);
    return (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
  endfunction

  function automatic int lane_start(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd1) return (off == 2'd3) ? 2 : int'(off);
    if (sz == 2'd2) return int'(off);
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    int len, st;
    len = lane_len(sz);
    st  = lane_start(sz, off);
    return 4'(((1 << len) - 1) << st);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [1:0] off,
                                           input logic [31:0] wd);
    logic [31:0] mask;
    int len;
    if (sz == 2'd2) return {4{wd[7:0]}};
    len  = lane_len(sz);
    mask = (len == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * len)) - 32'd1);
    return (wd & mask) << (8 * lane_start(sz, off));
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1) return off[0];
    if (sz == 2'd2) return 1'b0;
    return off != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected response.
  logic [W-1:0] mon_act, mon_exp;
  int mon_hits;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_hits = int'(st_done) + int'(wb_valid) + int'(bus_err) + int'(mis_sig);
      if (mon_hits > 1) begin
        chk("one_pulse", W'(mon_hits), W'(1));
      end else if (mon_hits == 1) begin
        if (wb_valid)     mon_act = resp(K_WB, wb_din, wb_addr, wb_signext_sel, wb_func3);
        else if (st_done) mon_act = resp(K_ST, 32'd0, 32'd0, 2'd0, 1'b0);
        else if (bus_err) mon_act = resp(K_ERR, 32'd0, 32'd0, 2'd0, 1'b0);
        else              mon_act = resp(K_MIS, 32'd0, 32'd0, 2'd0, 1'b0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: got %0h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("resp", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // gd: cycles of REQ before gnt.
  // rd: cycles after gnt until rvalid; 0 means rvalid together with gnt.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int gd, input int rd, input logic [31:0] rword);
    int n;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    n = 0;
    while (!ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ex_ready_idle", W'(ex_ready), W'(1));
    chk("req_idle", W'(dmem_req), W'(0));
    ex_valid = 1'b1; ex_we = we; ex_size = sz; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wd;
    e_be = we ? model_be(sz, addr[1:0]) : 4'hF;
    e_wd = model_wd(sz, addr[1:0], wd);
    if (model_mis(sz, addr[1:0]))       exp_q.push_back(resp(K_MIS, 32'd0, 32'd0, 2'd0, 1'b0));
    else if (we)                        exp_q.push_back(resp(K_ST, 32'd0, 32'd0, 2'd0, 1'b0));
    else if (rd > T)                    exp_q.push_back(resp(K_ERR, 32'd0, 32'd0, 2'd0, 1'b0));
    else                                exp_q.push_back(resp(K_WB, rword, addr, sz, uns));
    @(negedge clk);
    // Scramble EX inputs: the DUT must work from its latched copy.
    ex_valid = 1'b0; ex_we = 1'($urandom); ex_size = 2'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom;
    if (model_mis(sz, addr[1:0])) begin
      chk("mis_no_req", W'(dmem_req), W'(0));
    end else begin
      for (int i = 0; i <= gd; i++) begin
        chk("req_held", W'(dmem_req), W'(1));
        chk("req_busy", W'(ex_ready), W'(0));
        chk("req_addr", W'(dmem_addr), W'({addr[31:2], 2'b00}));
        chk("req_we", W'(dmem_we), W'(we));
        chk("req_be", W'(dmem_be), W'(e_be));
        if (we) chk("req_wdata", W'(dmem_wdata), W'(e_wd));
        dmem_gnt = (i == gd);
        if (i == gd && !we) begin
          dmem_rvalid = (rd == 0);
          dmem_rdata  = (rd == 0) ? rword : $urandom;
        end else begin
          dmem_rvalid = 1'($urandom);  // noise, must be ignored
          dmem_rdata  = $urandom;
        end
        @(negedge clk);
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (we)           chk("st_latency", W'(st_done), W'(1));
      else if (rd == 0) chk("ld_latency", W'(wb_valid), W'(1));
      else begin
        for (int j = 1; j <= rd; j++) begin
          if (j <= T) chk("wait_busy", W'(ex_ready), W'(0));
          if (j == T + 1) chk("timeout_pulse", W'(bus_err), W'(1));
          if (j == rd) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rword;
          end
          @(negedge clk);
          dmem_rvalid = 1'b0;
          dmem_rdata  = $urandom;
        end
        if (rd <= T) chk("wait_latency", W'(wb_valid), W'(1));
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("drain", W'(exp_q.size()), W'(0));
    exp_q.delete();
  endtask

  // Async reset while a load waits: the request drops at once and no pulse is produced.
  task automatic reset_in_wait();
    while (!ex_ready) @(negedge clk);
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'd0; ex_addr = 32'h300;
    @(negedge clk);
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", W'(ex_ready), W'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", W'(dmem_req), W'(0));
    chk("rst_ready", W'(ex_ready), W'(0));
    chk("rst_wb_din", W'(wb_din), W'(0));
    chk("rst_wb_addr", W'(wb_addr), W'(0));
    chk("rst_pulses", W'({wb_valid, st_done, bus_err}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_ignored", W'({wb_valid, wb_din}), W'(0));
    chk("post_rst_ready", W'(ex_ready), W'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", W'(ex_ready), W'(0));
    chk("reset_req", W'(dmem_req), W'(0));
    chk("reset_outs", W'({wb_valid, st_done, bus_err, wb_din, wb_addr, wb_signext_sel, wb_func3}), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(1'b1, 2'd2, 1'b0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0);      // sb lane 3
    do_op(1'b0, 2'd1, 1'b0, 32'h0000_2001, 32'd0, 3, 2, 32'h00FF_8000);      // lh, delayed
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'd0, 0, 0, 32'h1234_5678);      // lw zero-wait
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0080, 32'd0, 0, T + 1, 32'h0BAD_0BAD);  // timeout
    do_op(1'b0, 2'd2, 1'b1, 32'h0000_0085, 32'd0, 1, T, 32'hCAFE_F00D);      // rvalid on last cycle
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'd0, 0, 0, 32'h5555_AAAA);      // lw at offset 2
    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'hBEEF_1234, 2, 0, 32'd0);      // sh offset 1
    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0203, 32'hBEEF_1234, 0, 0, 32'd0);      // sh offset 3
    do_op(1'b1, 2'd3, 1'b0, 32'h0000_0300, 32'h8765_4321, 0, 0, 32'd0);      // illegal size

    reset_in_wait();

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      int rd;
      rd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 1, T + 2))
                                       : int'($urandom_range(0, 3));
      do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 3)), rd, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
